// File: rtl/bram_stream_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_stream_writer_pkg
//  Description : Shared definitions for the BRAM stream writer.
//                Holds the FSM state encoding, the default bus widths and a
//                constant-evaluable ceil(log2) helper used to size counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_stream_writer_pkg;

    localparam int unsigned c_def_data_size  = 8;
    localparam int unsigned c_def_addr_width = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < {32'd0, value}) begin
                result = 32'(i) + 32'd1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_stream_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bram_stream_writer_if
//  Description : Control, stream-input and BRAM port-A bundle of the writer.
//                master : sequencer / datapath side (drives work, clear,
//                         hold, base_addr, data_in, data_valid)
//                slave  : the writer (drives in_ready, ena, wea, addra,
//                         dina, is_full, is_empty, done, overflow)
//  Revision    : 1.0 - initial release
// ============================================================================
interface bram_stream_writer_if
    import bram_stream_writer_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = c_def_data_size,
    parameter int unsigned ADDR_WIDTH = c_def_addr_width
) ();

    logic                  work;
    logic                  clear;
    logic                  hold;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [DATA_SIZE-1:0]  data_in;
    logic                  data_valid;
    logic                  in_ready;
    logic                  ena;
    logic                  wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_SIZE-1:0]  dina;
    logic                  is_full;
    logic                  is_empty;
    logic                  done;
    logic                  overflow;

    modport master (
        output work, clear, hold, base_addr, data_in, data_valid,
        input  in_ready, ena, wea, addra, dina, is_full, is_empty, done, overflow
    );

    modport slave (
        input  work, clear, hold, base_addr, data_in, data_valid,
        output in_ready, ena, wea, addra, dina, is_full, is_empty, done, overflow
    );

endinterface
`default_nettype wire

// File: rtl/bram_stream_writer_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bram_stream_writer_sync_fifo
//  Description : DEPTH x WIDTH synchronous FIFO with circular pointers and an
//                occupancy counter. DEPTH need not be a power of two.
//  Ports       : clk, rst_n        clock / async active-low reset
//                flush_i           synchronous empty (pointers and count)
//                push_i, data_i    write request (ignored when full)
//                pop_i             read request (ignored when empty)
//                head_o            word at the read pointer (fall-through)
//                full_o, empty_o   occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_stream_writer_sync_fifo
    import bram_stream_writer_pkg::*;
#(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             flush_i,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] head_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned        c_ptr_w    = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int unsigned        c_cnt_w    = clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last_idx = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q;
    logic [c_ptr_w-1:0] rd_ptr_q;
    logic [c_cnt_w-1:0] count_q;

    logic               w_push;
    logic               w_pop;
    logic [c_ptr_w-1:0] w_wr_ptr_nxt;
    logic [c_ptr_w-1:0] w_rd_ptr_nxt;

    assign full_o  = (count_q == c_depth);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign w_push = push_i && !full_o && !flush_i;
    assign w_pop  = pop_i && !empty_o && !flush_i;

    // Explicit wrap so a non power-of-two depth still cycles 0..DEPTH-1.
    assign w_wr_ptr_nxt = (wr_ptr_q == c_last_idx) ? '0 : wr_ptr_q + 1'b1;
    assign w_rd_ptr_nxt = (rd_ptr_q == c_last_idx) ? '0 : rd_ptr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                rd_ptr_q <= w_rd_ptr_nxt;
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + 1'b1;
            end else if (w_pop && !w_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module      : bram_stream_writer
//  Description : Buffers a stream of result words in a small FIFO and drains
//                them into a BRAM port A at sequential (wrapping) addresses.
//                A run starts on work, writes WORD_COUNT words from base_addr
//                and then raises done until clear or work goes low.
//  Ports       : clk, rst_n   clock / async active-low reset
//                bus (slave)  work/clear/hold control, base_addr,
//                             data_in/data_valid/in_ready stream,
//                             ena/wea/addra/dina BRAM port A,
//                             is_full/is_empty/done/overflow status
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_stream_writer
    import bram_stream_writer_pkg::*;
#(
    parameter int unsigned QUEUE_SIZE = 5,
    parameter int unsigned DATA_SIZE  = c_def_data_size,
    parameter int unsigned ADDR_WIDTH = c_def_addr_width,
    parameter int unsigned WORD_COUNT = 1024
) (
    input wire logic            clk,
    input wire logic            rst_n,
    bram_stream_writer_if.slave bus
);

    localparam int unsigned        c_cnt_w      = clog2(WORD_COUNT + 1);
    localparam logic [c_cnt_w-1:0] c_word_count = c_cnt_w'(WORD_COUNT);

    state_t                state_q,    state_d;
    logic [ADDR_WIDTH-1:0] addr_ptr_q, addr_ptr_d;
    logic [c_cnt_w-1:0]    wr_cnt_q,   wr_cnt_d;
    logic                  ena_q,      ena_d;
    logic [ADDR_WIDTH-1:0] addra_q,    addra_d;
    logic [DATA_SIZE-1:0]  dina_q,     dina_d;
    logic                  overflow_q, overflow_d;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [DATA_SIZE-1:0]  w_fifo_head;
    logic                  w_in_ready;
    logic                  w_push;
    logic                  w_can_write;
    logic                  w_write;
    logic                  w_bypass;
    logic                  w_fifo_push;
    logic                  w_fifo_pop;
    logic [DATA_SIZE-1:0]  w_wr_word;

    assign w_in_ready  = !w_fifo_full;
    assign w_push      = bus.data_valid && w_in_ready && !bus.clear;
    assign w_can_write = (state_q == ST_RUN) && !bus.hold && !bus.clear &&
                         (wr_cnt_q != c_word_count);
    assign w_write     = w_can_write && (!w_fifo_empty || w_push);

    // An arriving word that would be written the same cycle skips the FIFO
    // storage; this gives the single-cycle push-to-strobe latency.
    assign w_bypass    = w_write && w_fifo_empty;
    assign w_fifo_push = w_push && !w_bypass;
    assign w_fifo_pop  = w_write && !w_fifo_empty;
    assign w_wr_word   = w_fifo_empty ? bus.data_in : w_fifo_head;

    bram_stream_writer_sync_fifo #(
        .DEPTH (QUEUE_SIZE),
        .WIDTH (DATA_SIZE)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (bus.clear),
        .push_i  (w_fifo_push),
        .data_i  (bus.data_in),
        .pop_i   (w_fifo_pop),
        .head_o  (w_fifo_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        addr_ptr_d = addr_ptr_q;
        wr_cnt_d   = wr_cnt_q;
        ena_d      = 1'b0;
        addra_d    = addra_q;
        dina_d     = dina_q;
        overflow_d = overflow_q || (bus.data_valid && !w_in_ready);

        if (bus.clear) begin
            state_d    = ST_IDLE;
            addr_ptr_d = '0;
            wr_cnt_d   = '0;
            overflow_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.work) begin
                        state_d    = ST_RUN;
                        addr_ptr_d = bus.base_addr;
                        wr_cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    // The count is examined one cycle after the final write,
                    // so done rises the cycle after the last strobe.
                    if (wr_cnt_q == c_word_count) begin
                        state_d = ST_DONE;
                    end else if (w_write) begin
                        ena_d      = 1'b1;
                        addra_d    = addr_ptr_q;
                        dina_d     = w_wr_word;
                        addr_ptr_d = addr_ptr_q + 1'b1;
                        wr_cnt_d   = wr_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!bus.work) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_ptr_q <= '0;
            wr_cnt_q   <= '0;
            ena_q      <= 1'b0;
            addra_q    <= '0;
            dina_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_ptr_q <= addr_ptr_d;
            wr_cnt_q   <= wr_cnt_d;
            ena_q      <= ena_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.ena      = ena_q;
    assign bus.wea      = ena_q;
    assign bus.addra    = addra_q;
    assign bus.dina     = dina_q;
    assign bus.is_full  = w_fifo_full;
    assign bus.is_empty = w_fifo_empty;
    assign bus.done     = (state_q == ST_DONE);
    assign bus.overflow = overflow_q;

endmodule
`default_nettype wire
